// File: rtl/pattern_serializer_if.sv
// Load handshake and serial output bundle for pattern_serializer.
// Latency: none, wires only.
// Backpressure: load_ready from the slave side gates load_valid from the master side.
// Optional macro PATTERN_SERIALIZER_PARITY_EN adds parity_flag.
interface pattern_serializer_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    logic             parity_flag;
`endif

    // Stimulus side: issues loads and aborts, watches the serial line.
    modport master (
        output load_valid, pattern, len, repeat_n, abort,
        input  load_ready, x, x_valid, busy, done
`ifdef PATTERN_SERIALIZER_PARITY_EN
        , input parity_flag
`endif
    );

    // Serializer side.
    modport slave (
        input  load_valid, pattern, len, repeat_n, abort,
        output load_ready, x, x_valid, busy, done
`ifdef PATTERN_SERIALIZER_PARITY_EN
        , output parity_flag
`endif
    );
endinterface

// File: rtl/pattern_serializer.sv
// Serial bit-pattern transmitter: sends pattern[len-1:0] MSB-first, repeat_n+1 times, GAP idle cycles between.
// Latency: first bit one cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: load_ready only in IDLE; loads while busy are ignored (no queueing). Macro PATTERN_SERIALIZER_PARITY_EN appends an even-parity bit per repetition.
module pattern_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_serializer_if.slave  bus
);
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] last_idx;   // L-1 of the captured frame
    logic [LEN_W-1:0] bit_cnt;    // index of the bit currently on x
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             x_q;
    logic             x_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [LEN_W-1:0] ld_last;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    logic             par_phase;  // the parity bit of this repetition is on x
    logic             parity_q;
    logic             par_bit;
`endif

    // Single bit of a word selected by a runtime index, without a narrow-index width mismatch.
    function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] s;
        s = w >> idx;
        return s[0];
    endfunction

    // Clamp the requested length: 0 or anything above WIDTH means a full-width frame.
    always_comb begin
        ld_last = LEN_W'(WIDTH - 1);
        if (bus.len != '0 && bus.len <= LEN_W'(WIDTH))
            ld_last = bus.len - 1'b1;
    end

`ifdef PATTERN_SERIALIZER_PARITY_EN
    // Even parity over the active field pat[last_idx:0].
    always_comb begin
        par_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) <= last_idx)
                par_bit = par_bit ^ pat[i];
        end
    end
`endif

    // Sequencer: every output is registered so x carries the bit selected at the previous edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pat       <= '0;
            last_idx  <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            par_phase <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort is meaningless here; a simultaneous load wins.
                    if (bus.load_valid) begin
                        pat       <= bus.pattern;
                        last_idx  <= ld_last;
                        bit_cnt   <= ld_last;
                        rep_cnt   <= bus.repeat_n;
                        x_q       <= bit_at(bus.pattern, ld_last);
                        x_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ST_SEND;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                        par_phase <= 1'b0;
`endif
                    end
                end

                ST_SEND: begin
                    if (bus.abort) begin
                        state     <= ST_IDLE;
                        x_q       <= IDLE_BIT;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                        par_phase <= 1'b0;
                        parity_q  <= 1'b0;
`endif
                    end else if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                        x_q     <= bit_at(pat, bit_cnt - 1'b1);
`ifdef PATTERN_SERIALIZER_PARITY_EN
                    end else if (!par_phase) begin
                        par_phase <= 1'b1;
                        parity_q  <= 1'b1;
                        x_q       <= par_bit;
`endif
                    end else begin
                        // Last bit of this repetition is on x now.
`ifdef PATTERN_SERIALIZER_PARITY_EN
                        par_phase <= 1'b0;
                        parity_q  <= 1'b0;
`endif
                        if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - 1'b1;
                            bit_cnt <= last_idx;
                            if (GAP > 0) begin
                                state     <= ST_GAP;
                                gap_cnt   <= GAP_W'(GAP - 1);
                                x_q       <= IDLE_BIT;
                                x_valid_q <= 1'b0;
                            end else begin
                                x_q       <= bit_at(pat, last_idx);
                                x_valid_q <= 1'b1;
                            end
                        end else begin
                            state     <= ST_IDLE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            x_q       <= IDLE_BIT;
                            x_valid_q <= 1'b0;
                        end
                    end
                end

                ST_GAP: begin
                    if (bus.abort) begin
                        state     <= ST_IDLE;
                        x_q       <= IDLE_BIT;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state     <= ST_SEND;
                        x_q       <= bit_at(pat, last_idx);
                        x_valid_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    x_q       <= IDLE_BIT;
                    x_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = (state == ST_IDLE);
    assign bus.x          = x_q;
    assign bus.x_valid    = x_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    assign bus.parity_flag = parity_q;
`endif

endmodule
